demux1_4_pipe: RTL and testbench
================================

# demux1_4_pipe

Registered 1-to-4 stream demultiplexer: routes each accepted input word to one of four output channels selected by a 2-bit select sampled with the data, using valid/ready handshakes on every port. It is the distribution-side counterpart of the team's 4:1 selector tree. Channel index matches that tree: channel = {S1,S0}, with S1 resolved at the first level and S0 at the second. It sits between a single producer and four independent consumers and carries full throughput when the consumers keep up.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination channel; bit 1 = S1, bit 0 = S0
- in_valid  input  1  producer offers in_data/in_sel
- in_ready  output  1  block accepts this cycle
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  4  per-channel word available
- out_ready  input  4  per-channel consumer accepts
- busy  output  1  any stage holds a word

## Operation
- A transfer on any port occurs at a rising edge where valid && ready are both high.
- Pipeline is a tree of three 1:2 stages:
  - Stage A takes the input and splits on S1, carrying S0 with the word.
  - Stage B0 takes A's output 0 and serves channels 0/1.
  - Stage B1 takes A's output 1 and serves channels 2/3.
- Each stage holds one entry with state EMPTY or FULL, a data register, and a select register (A: S1 and S0; B: S0).
- Stage transitions:
  - EMPTY→FULL on input transfer.
  - FULL→EMPTY on output transfer with no input transfer.
  - FULL→FULL with new contents on simultaneous output and input transfer.
- Stage ready_in = EMPTY || (output transfer happening this cycle). This is combinational from downstream ready. There is no combinational path from in_valid to out_valid.
- A stage's outputs: valid_out[j] = FULL && (sel == j); data_out = data register on both legs.
- in_ready = stage A ready_in; busy = OR of the three FULL bits.
- Ordering:
  - Words to the same channel leave in acceptance order.
  - A stalled channel blocks stage A once A holds a word for that subtree (head-of-line blocking). This is intended.
  - No word is dropped or duplicated.
- Data on non-valid channels holds its last value. Consumers must ignore it.
- While rst is high: in_ready = 0 and all state is forced EMPTY.

## Timing
- Reset values:
  - out_valid = 4'b0000, out_data = 0, busy = 0.
  - in_ready = 0 during reset; 1 in the first cycle after rst falls.
- Latency: a word accepted at edge N is presented on out_valid in the cycle after edge N+1 (2 cycles) when downstream is free.
- Throughput: one word per cycle sustained to any mix of channels whose out_ready stays high.
- Backpressure: with a channel's out_ready low, at most one word waits in the B stage and one in stage A. in_ready drops no later than the cycle after the second blocked word is accepted.
- Reset mid-operation: all held words are discarded at the reset edge, and out_valid is 0 the following cycle.
- Select changes while in_valid is high and in_ready is low are permitted. Only in_sel at the transfer edge matters.

## Structure
- Shared package/header: channel count (4), select width (2), and stage state encodings EMPTY=1'b0, FULL=1'b1.
- Sub-module demux1_2_stage (parameters WIDTH and SELW for carried select bits) is instantiated three times. The top level contains only wiring, slicing of the carried select, and the busy OR.
- Expected size: about 80 lines for the stage and about 80 for the top.

## Test plan
- Reset: drive rst for 3 cycles with in_valid=1.
  - Required: no acceptance, out_valid=0000, busy=0.
  - Required: in_ready=1 on the first cycle after release.
- Routing: out_ready=1111; send 0x11, 0x22, 0x33, 0x44 with sel 0, 1, 2, 3 on consecutive cycles.
  - Required: each word appears once on channel 0, 1, 2, 3 respectively, 2 cycles after acceptance, with in_ready held at 1 throughout.
- Stream: send 0x00–0x0F back-to-back to sel=2 with out_ready=1111.
  - Required: 16 consecutive cycles of out_valid=0100 with data in order, and no in_ready deassertion.
- Backpressure: set out_ready[1]=0 and send 0xA0, 0xA1, 0xA2 to sel=1.
  - Required: 0xA0 is held on channel 1, 0xA1 is held in stage A, and in_ready=0.
  - Release out_ready[1]: 0xA0, 0xA1, 0xA2 are delivered in order, with no loss.
- Head-of-line: hold out_ready[0]=0; send 0x5A to sel 0, then 0x5B to sel 0, then 0xC3 to sel 3.
  - Required: 0xC3 is not delivered until channel 0 drains.
  - Once channel 0 drains, 0xC3 arrives on channel 3 intact.
- Reset mid-flight: assert rst while two words are buffered.
  - Required: both words are discarded, and out_valid=0000 and busy=0 on the next cycle.
  - Required: a new word sent with sel=0 is delivered normally.

Source files
------------

// File: rtl/demux1_4_pipe_pkg.sv
// Shared constants and stage state encoding for the 1:4 stream demultiplexer tree.
package demux1_4_pipe_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/demux1_2_stage.sv
// One-entry registered 1:2 split stage with valid/ready on every leg.
// The top select bit picks the output leg; all select bits travel with the word.
module demux1_2_stage
    import demux1_4_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SELW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_sel,
    output logic [1:0]       out_valid,
    input  logic [1:0]       out_ready,
    output logic             full
);

    stage_state_t     state;
    stage_state_t     state_next;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;
    logic             route;
    logic             in_xfer;
    logic             out_xfer;

    assign route        = sel_q[SELW-1];
    assign out_valid[0] = (state == FULL) && !route;
    assign out_valid[1] = (state == FULL) && route;
    assign out_xfer     = |(out_valid & out_ready);

    // Accepting while draining keeps the stage at one word per cycle.
    assign in_ready = !rst && ((state == EMPTY) || out_xfer);
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_next = state;
        if (in_xfer) begin
            state_next = FULL;
        end else if (out_xfer) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (in_xfer) begin
            data_q <= in_data;
            sel_q  <= in_sel;
        end
    end

    assign out_data = data_q;
    assign out_sel  = sel_q;
    assign full     = (state == FULL);

endmodule

// File: rtl/demux1_4_pipe.sv
// Registered 1:4 demultiplexer built as a tree of three 1:2 stages:
// stage A splits on S1, stages B0/B1 split on S0 to reach channel {S1,S0}.
module demux1_4_pipe
    import demux1_4_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy
);

    logic [WIDTH-1:0] a_data;
    logic             a_s1_unused;
    logic             a_s0;
    logic [1:0]       a_valid;
    logic [1:0]       a_ready;
    logic             a_full;

    logic [WIDTH-1:0] b0_data;
    logic [WIDTH-1:0] b1_data;
    logic             b0_sel_unused;
    logic             b1_sel_unused;
    logic             b0_full;
    logic             b1_full;

    demux1_2_stage #(.WIDTH(WIDTH), .SELW(SEL_W)) u_stage_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (a_data),
        .out_sel   ({a_s1_unused, a_s0}),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .full      (a_full)
    );

    demux1_2_stage #(.WIDTH(WIDTH), .SELW(1)) u_stage_b0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_data),
        .in_sel    (a_s0),
        .in_valid  (a_valid[0]),
        .in_ready  (a_ready[0]),
        .out_data  (b0_data),
        .out_sel   (b0_sel_unused),
        .out_valid (out_valid[1:0]),
        .out_ready (out_ready[1:0]),
        .full      (b0_full)
    );

    demux1_2_stage #(.WIDTH(WIDTH), .SELW(1)) u_stage_b1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_data),
        .in_sel    (a_s0),
        .in_valid  (a_valid[1]),
        .in_ready  (a_ready[1]),
        .out_data  (b1_data),
        .out_sel   (b1_sel_unused),
        .out_valid (out_valid[3:2]),
        .out_ready (out_ready[3:2]),
        .full      (b1_full)
    );

    // Each B stage drives the same register onto both of its channels.
    assign out_data = {b1_data, b1_data, b0_data, b0_data};
    assign busy     = a_full | b0_full | b1_full;

endmodule

// File: tb/tb_demux1_4_pipe.sv
// Self-checking bench for demux1_4_pipe: per-cycle vector table plus
// hand-written reset, streaming and mid-flight reset sequences.
module tb_demux1_4_pipe;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ready;
        logic [3:0] exp_valid;
        logic [7:0] exp_data;
        logic       exp_in_ready;
        logic       exp_busy;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    int total_checks;
    int passed_checks;
    vec_t vecs[$];

    demux1_4_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [7:0] d, input logic [1:0] s, input logic v,
                           input logic [3:0] r, input logic [3:0] ev, input logic [7:0] ed,
                           input logic eir, input logic eb);
        vec_t t;
        t.data = d; t.sel = s; t.valid = v; t.ready = r;
        t.exp_valid = ev; t.exp_data = ed; t.exp_in_ready = eir; t.exp_busy = eb;
        vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input vec_t v);
        in_data   = v.data;
        in_sel    = v.sel;
        in_valid  = v.valid;
        out_ready = v.ready;
    endtask

    task automatic check_channel_data(input string name, input logic [3:0] ev, input logic [7:0] ed);
        for (int k = 0; k < 4; k++) begin
            if (ev[k]) check(name, out_data[k*WIDTH +: WIDTH], ed);
        end
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".out_valid"}, {4'b0, out_valid}, {4'b0, v.exp_valid});
        check({tag, ".in_ready"}, {7'b0, in_ready}, {7'b0, v.exp_in_ready});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, v.exp_busy});
        check_channel_data({tag, ".data"}, v.exp_valid, v.exp_data);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;

        // Routing: one word per channel, 2-cycle latency, in_ready stays high.
        add_vec(8'h11, 2'd0, 1'b1, 4'hF, 4'b0000, 8'h00, 1'b1, 1'b0);
        add_vec(8'h22, 2'd1, 1'b1, 4'hF, 4'b0000, 8'h00, 1'b1, 1'b1);
        add_vec(8'h33, 2'd2, 1'b1, 4'hF, 4'b0001, 8'h11, 1'b1, 1'b1);
        add_vec(8'h44, 2'd3, 1'b1, 4'hF, 4'b0010, 8'h22, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0100, 8'h33, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b1000, 8'h44, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0000, 8'h00, 1'b1, 1'b0);
        // Backpressure on channel 1: A0 in B0, A1 in A, A2 stalled.
        add_vec(8'hA0, 2'd1, 1'b1, 4'hD, 4'b0000, 8'h00, 1'b1, 1'b0);
        add_vec(8'hA1, 2'd1, 1'b1, 4'hD, 4'b0000, 8'h00, 1'b1, 1'b1);
        add_vec(8'hA2, 2'd1, 1'b1, 4'hD, 4'b0010, 8'hA0, 1'b0, 1'b1);
        add_vec(8'hA2, 2'd1, 1'b1, 4'hD, 4'b0010, 8'hA0, 1'b0, 1'b1);
        add_vec(8'hA2, 2'd1, 1'b1, 4'hF, 4'b0010, 8'hA0, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0010, 8'hA1, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0010, 8'hA2, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0000, 8'h00, 1'b1, 1'b0);
        // Head-of-line: C3 for channel 3 waits behind stalled channel 0.
        add_vec(8'h5A, 2'd0, 1'b1, 4'hE, 4'b0000, 8'h00, 1'b1, 1'b0);
        add_vec(8'h5B, 2'd0, 1'b1, 4'hE, 4'b0000, 8'h00, 1'b1, 1'b1);
        add_vec(8'hC3, 2'd3, 1'b1, 4'hE, 4'b0001, 8'h5A, 1'b0, 1'b1);
        add_vec(8'hC3, 2'd2, 1'b1, 4'hE, 4'b0001, 8'h5A, 1'b0, 1'b1);
        add_vec(8'hC3, 2'd3, 1'b1, 4'hF, 4'b0001, 8'h5A, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0001, 8'h5B, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b1000, 8'hC3, 1'b1, 1'b1);
        add_vec(8'h00, 2'd0, 1'b0, 4'hF, 4'b0000, 8'h00, 1'b1, 1'b0);

        // Reset held for 3 cycles with a word offered.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd0; out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset.in_ready", {7'b0, in_ready}, 8'h00);
            check("reset.out_valid", {4'b0, out_valid}, 8'h00);
            check("reset.busy", {7'b0, busy}, 8'h00);
            check("reset.out_data", out_data[7:0], 8'h00);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("release.in_ready", {7'b0, in_ready}, 8'h01);
        check("release.out_valid", {4'b0, out_valid}, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
        end

        // Stream 0x00..0x0F to channel 2 back-to-back.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            in_valid = (i < 16); in_data = 8'(i); in_sel = 2'd2; out_ready = 4'hF;
            #1;
            check("stream.in_ready", {7'b0, in_ready}, 8'h01);
            if (i >= 2 && i < 18) begin
                check("stream.out_valid", {4'b0, out_valid}, 8'h04);
                check("stream.data", out_data[2*WIDTH +: WIDTH], 8'(i - 2));
            end else begin
                check("stream.out_valid_idle", {4'b0, out_valid}, 8'h00);
            end
        end

        // Two words buffered toward a stalled channel 0, then reset.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h91; in_sel = 2'd0; out_ready = 4'h0;
        @(negedge clk);
        in_data = 8'h92;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("midrst.in_ready", {7'b0, in_ready}, 8'h00);
        check("midrst.busy_before", {7'b0, busy}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.out_valid", {4'b0, out_valid}, 8'h00);
        check("midrst.busy", {7'b0, busy}, 8'h00);
        out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd0;
        #1;
        check("postrst.in_ready", {7'b0, in_ready}, 8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("postrst.out_valid_n1", {4'b0, out_valid}, 8'h00);
        @(negedge clk);
        #1;
        check("postrst.out_valid", {4'b0, out_valid}, 8'h01);
        check("postrst.data", out_data[7:0], 8'h77);
        @(negedge clk);
        #1;
        check("postrst.drained", {4'b0, out_valid}, 8'h00);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
